// File: rtl/secuenciador_cs_campos_pkg.sv
// Shared types and helpers for the field chip-select sequencer.
// The blink feature of the top is enabled with the CS_PARPADEO_EN macro.
package cs_campos_pkg;

   typedef enum logic [1:0] {
      REPOSO         = 2'd0,
      CONFIG         = 2'd1,
      ESPERA_LIBERAR = 2'd2
   } estado_t;

   localparam int unsigned G_HORA  = 32'd0;
   localparam int unsigned G_FECHA = 32'd1;
   localparam int unsigned G_TIMER = 32'd2;

   localparam int unsigned ANCHO_CUENTA = 32'd3;
   localparam int unsigned MAX_GRUPOS   = 32'd16;
   localparam int unsigned ANCHO_VEC    = ANCHO_CUENTA * MAX_GRUPOS;

   // Field count of one group, packed 3 bits per group, LSB first.
   function automatic logic [ANCHO_CUENTA-1:0] campos_de_grupo(
      input logic [ANCHO_VEC-1:0] vec,
      input int unsigned          grupo
   );
      return vec[grupo*ANCHO_CUENTA +: ANCHO_CUENTA];
   endfunction

endpackage

// File: rtl/secuenciador_cs_campos_contador.sv
// Saturating up-counter with synchronous clear; flags when the terminal
// value LIMITE is held.
module contador_timeout #(
   parameter int unsigned ANCHO  = 32'd4,
   parameter int unsigned LIMITE = 32'd15
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expira_o
);

   localparam logic [ANCHO-1:0] TOPE = ANCHO'(LIMITE);

   logic [ANCHO-1:0] cuenta_q;
   logic [ANCHO-1:0] cuenta_d;

   // Next count: clear wins, then count up until the terminal value.
   always_comb begin
      cuenta_d = cuenta_q;
      if (clr_i) begin
         cuenta_d = '0;
      end else if (en_i && (cuenta_q != TOPE)) begin
         cuenta_d = cuenta_q + ANCHO'(1);
      end else begin
         cuenta_d = cuenta_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cuenta_q <= '0;
      end else begin
         cuenta_q <= cuenta_d;
      end
   end

   assign expira_o = (cuenta_q == TOPE);

endmodule

// File: rtl/secuenciador_cs_campos.sv
// Field cursor sequencer: latches a configuration group and drives one field
// chip-select at a time. Define CS_PARPADEO_EN to build the blink output.
module secuenciador_cs_campos
   import cs_campos_pkg::*;
#(
   parameter int unsigned             N_GRUPOS        = 32'd3,
   parameter int unsigned             CAMPOS_MAX      = 32'd4,
   parameter logic [3*N_GRUPOS-1:0]   CAMPOS_VEC      = 9'h0E3,
   parameter int unsigned             TIMEOUT_CICLOS  = 32'd100_000_000,
   parameter int unsigned             PARPADEO_CICLOS = 32'd25_000_000,
   localparam int unsigned            GW = (N_GRUPOS > 32'd1) ? $clog2(N_GRUPOS) : 32'd1,
   localparam int unsigned            CW = (CAMPOS_MAX > 32'd1) ? $clog2(CAMPOS_MAX) : 32'd1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_GRUPOS-1:0]            funcion_conf,
   input  logic                           flag_mostrar_count,
   input  logic                           pulse_siguiente,
   input  logic                           pulse_actividad,
   output logic [N_GRUPOS*CAMPOS_MAX-1:0] cs_campo,
   output logic                           cs_lectura_timer,
   output logic                           modo_conf,
   output logic [GW-1:0]                  grupo_activo,
   output logic [CW-1:0]                  campo_activo,
   output logic                           timeout_evento,
   output logic                           parpadeo
);

   localparam int unsigned N_CS    = N_GRUPOS * CAMPOS_MAX;
   localparam int unsigned ANCHO_TO = (TIMEOUT_CICLOS > 32'd1) ? $clog2(TIMEOUT_CICLOS) : 32'd1;
   localparam logic [ANCHO_VEC-1:0] VEC_EXT = ANCHO_VEC'(CAMPOS_VEC);

   for (genvar g = 0; g < N_GRUPOS; g++) begin : g_chk_campos
      if ((campos_de_grupo(VEC_EXT, g) == 3'd0) || (campos_de_grupo(VEC_EXT, g) > CAMPOS_MAX)) begin : g_err
         $error("field count of a group out of range");
      end
   end
   if ((TIMEOUT_CICLOS < 32'd2) || (PARPADEO_CICLOS < 32'd1)) begin : g_chk_tiempos
      $error("timeout/blink cycle counts out of range");
   end

   estado_t                estado_q, estado_d;
   logic [GW-1:0]          grupo_q, grupo_d;
   logic [CW-1:0]          campo_q, campo_d;
   logic [ANCHO_CUENTA-1:0] n_campos_s;
   logic                   sel_valida_s;
   logic [GW-1:0]          sel_idx_s;
   logic                   avance_s;
   logic                   cambio_grupo_s;
   logic                   expira_to_s;
   logic                   clr_to_s;
   logic                   en_to_s;

   logic [N_CS-1:0]        cs_campo_q, cs_campo_d;
   logic                   cs_lect_q, cs_lect_d;
   logic                   modo_q, modo_d;
   logic                   timeout_ev_q, timeout_ev_d;
   logic                   parp_q, parp_d;

   assign n_campos_s = campos_de_grupo(VEC_EXT, 32'(grupo_q));

   // Decode the group request: valid only when exactly one bit is set.
   always_comb begin
      sel_valida_s = ($countones(funcion_conf) == 32'd1);
      sel_idx_s    = '0;
      for (int unsigned i = 0; i < N_GRUPOS; i++) begin
         if (funcion_conf[i]) begin
            sel_idx_s = GW'(i);
         end else begin
            sel_idx_s = sel_idx_s;
         end
      end
   end

   // FSM state, latched group and cursor.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q <= REPOSO;
         grupo_q  <= '0;
         campo_q  <= '0;
      end else begin
         estado_q <= estado_d;
         grupo_q  <= grupo_d;
         campo_q  <= campo_d;
      end
   end

   // Next-state logic; a group change outranks a cursor pulse, any pulse outranks expiry.
   always_comb begin
      estado_d       = estado_q;
      grupo_d        = grupo_q;
      campo_d        = campo_q;
      timeout_ev_d   = 1'b0;
      avance_s       = 1'b0;
      cambio_grupo_s = 1'b0;
      case (estado_q)
         REPOSO: begin
            if (sel_valida_s) begin
               estado_d = CONFIG;
               grupo_d  = sel_idx_s;
               campo_d  = '0;
            end else begin
               estado_d = REPOSO;
            end
         end
         CONFIG: begin
            if (!sel_valida_s) begin
               estado_d = REPOSO;
            end else if (sel_idx_s != grupo_q) begin
               grupo_d        = sel_idx_s;
               campo_d        = '0;
               cambio_grupo_s = 1'b1;
            end else if (pulse_siguiente) begin
               avance_s = 1'b1;
               if ((32'(campo_q) + 32'd1) >= 32'(n_campos_s)) begin
                  campo_d = '0;
               end else begin
                  campo_d = campo_q + CW'(1);
               end
            end else if (pulse_actividad) begin
               estado_d = CONFIG;
            end else if (expira_to_s) begin
               estado_d     = ESPERA_LIBERAR;
               timeout_ev_d = 1'b1;
            end else begin
               estado_d = CONFIG;
            end
         end
         ESPERA_LIBERAR: begin
            if (funcion_conf == '0) begin
               estado_d = REPOSO;
            end else begin
               estado_d = ESPERA_LIBERAR;
            end
         end
         default: begin
            estado_d = REPOSO;
         end
      endcase
   end

   assign en_to_s  = (estado_q == CONFIG);
   assign clr_to_s = (estado_q != CONFIG) || (estado_d != CONFIG) || pulse_siguiente
                     || pulse_actividad || cambio_grupo_s;

   contador_timeout #(
      .ANCHO  (ANCHO_TO),
      .LIMITE (TIMEOUT_CICLOS - 32'd1)
   ) u_timeout (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (clr_to_s),
      .en_i     (en_to_s),
      .expira_o (expira_to_s)
   );

`ifdef CS_PARPADEO_EN
   localparam int unsigned ANCHO_BL = (PARPADEO_CICLOS > 32'd1) ? $clog2(PARPADEO_CICLOS) : 32'd1;

   logic reinicio_bl_s;
   logic clr_bl_s;
   logic expira_bl_s;

   assign reinicio_bl_s = (estado_d == CONFIG)
                          && ((estado_q != CONFIG) || avance_s || cambio_grupo_s);
   assign clr_bl_s      = reinicio_bl_s || expira_bl_s || (estado_d != CONFIG);

   contador_timeout #(
      .ANCHO  (ANCHO_BL),
      .LIMITE (PARPADEO_CICLOS - 32'd1)
   ) u_parpadeo (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (clr_bl_s),
      .en_i     (1'b1),
      .expira_o (expira_bl_s)
   );

   // Blink phase restarts high on entry and on every cursor or group change.
   always_comb begin
      parp_d = parp_q;
      if (estado_d != CONFIG) begin
         parp_d = 1'b0;
      end else if (reinicio_bl_s) begin
         parp_d = 1'b1;
      end else if (expira_bl_s) begin
         parp_d = ~parp_q;
      end else begin
         parp_d = parp_q;
      end
   end
`else
   assign parp_d = 1'b0;
`endif

   // Output decode from the next state so every output lands one cycle after its inputs.
   always_comb begin
      cs_campo_d = '0;
      for (int unsigned i = 0; i < N_CS; i++) begin
         if ((estado_d == CONFIG) && (i == (32'(grupo_d) * CAMPOS_MAX + 32'(campo_d)))) begin
            cs_campo_d[i] = 1'b1;
         end else begin
            cs_campo_d[i] = 1'b0;
         end
      end
      modo_d    = (estado_d == CONFIG);
      cs_lect_d = flag_mostrar_count
                  & ~((estado_d == CONFIG) && (grupo_d == GW'(N_GRUPOS - 32'd1)));
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_campo_q   <= '0;
         cs_lect_q    <= 1'b0;
         modo_q       <= 1'b0;
         timeout_ev_q <= 1'b0;
         parp_q       <= 1'b0;
      end else begin
         cs_campo_q   <= cs_campo_d;
         cs_lect_q    <= cs_lect_d;
         modo_q       <= modo_d;
         timeout_ev_q <= timeout_ev_d;
         parp_q       <= parp_d;
      end
   end

   assign cs_campo         = cs_campo_q;
   assign cs_lectura_timer = cs_lect_q;
   assign modo_conf        = modo_q;
   assign grupo_activo     = grupo_q;
   assign campo_activo     = campo_q;
   assign timeout_evento   = timeout_ev_q;
   assign parpadeo         = parp_q;

endmodule

// File: tb/tb_secuenciador_cs_campos.sv
// Self-checking bench for secuenciador_cs_campos: vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_secuenciador_cs_campos;

   localparam int TO = 16;
   localparam int PB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  funcion_conf;
   logic        flag_mostrar_count;
   logic        pulse_siguiente;
   logic        pulse_actividad;
   logic [11:0] cs_campo;
   logic        cs_lectura_timer;
   logic        modo_conf;
   logic [1:0]  grupo_activo;
   logic [1:0]  campo_activo;
   logic        timeout_evento;
   logic        parpadeo;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   secuenciador_cs_campos #(
      .TIMEOUT_CICLOS  (TO),
      .PARPADEO_CICLOS (PB)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .funcion_conf       (funcion_conf),
      .flag_mostrar_count (flag_mostrar_count),
      .pulse_siguiente    (pulse_siguiente),
      .pulse_actividad    (pulse_actividad),
      .cs_campo           (cs_campo),
      .cs_lectura_timer   (cs_lectura_timer),
      .modo_conf          (modo_conf),
      .grupo_activo       (grupo_activo),
      .campo_activo       (campo_activo),
      .timeout_evento     (timeout_evento),
      .parpadeo           (parpadeo)
   );

   // Behavioural model: mode 0 = rest, 1 = configuring, 2 = waiting for release.
   int m_modo, m_grp, m_cur, m_idle, m_edad;
   bit m_ev, m_flag;
   int campos[3] = '{3, 4, 3};

   function automatic void chk(string nombre, logic [31:0] act, logic [31:0] esp);
      tests++;
      if (act !== esp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, esp, $time);
      end
   endfunction

   function automatic void modelo_reset();
      m_modo = 0; m_grp = 0; m_cur = 0; m_idle = 0; m_edad = 0; m_ev = 0; m_flag = 0;
   endfunction

   function automatic void modelo_paso(logic [2:0] fc, logic p_s, logic p_a);
      int unos = $countones(fc);
      int idx  = 0;
      for (int i = 0; i < 3; i++) if (fc[i]) idx = i;
      m_ev = 0;
      if (m_modo == 0) begin
         if (unos == 1) begin
            m_modo = 1; m_grp = idx; m_cur = 0; m_idle = 0; m_edad = 0;
         end
      end else if (m_modo == 1) begin
         if (unos != 1) m_modo = 0;
         else if (idx != m_grp) begin
            m_grp = idx; m_cur = 0; m_idle = 0; m_edad = 0;
         end else if (p_s) begin
            m_cur = (m_cur + 1) % campos[m_grp]; m_idle = 0; m_edad = 0;
         end else begin
            m_edad++;
            if (p_a) m_idle = 0;
            else if (m_idle == TO - 1) begin m_modo = 2; m_ev = 1; end
            else m_idle++;
         end
      end else begin
         if (fc == 3'b000) m_modo = 0;
      end
   endfunction

   function automatic logic [11:0] esp_cs();
      logic [11:0] v = 12'd0;
      if (m_modo == 1) v[m_grp*4 + m_cur] = 1'b1;
      return v;
   endfunction

   function automatic logic esp_parp();
`ifdef CS_PARPADEO_EN
      return (m_modo == 1) && (((m_edad / PB) % 2) == 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic void chk_modelo();
      chk("cs_campo",   32'(cs_campo),         32'(esp_cs()));
      chk("modo_conf",  32'(modo_conf),        32'(m_modo == 1));
      chk("cs_lectura", 32'(cs_lectura_timer), 32'(m_flag && !(m_modo == 1 && m_grp == 2)));
      chk("timeout_ev", 32'(timeout_evento),   32'(m_ev));
      chk("parpadeo",   32'(parpadeo),         32'(esp_parp()));
      if (m_modo == 1) begin
         chk("grupo", 32'(grupo_activo), 32'(m_grp));
         chk("campo", 32'(campo_activo), 32'(m_cur));
      end
   endfunction

   // One clock: drive at the falling edge, model steps at the rising edge, sample at the next falling edge.
   task automatic ciclo(input logic [2:0] fc, input logic fl, input logic p_s, input logic p_a);
      funcion_conf       = fc;
      flag_mostrar_count = fl;
      pulse_siguiente    = p_s;
      pulse_actividad    = p_a;
      @(posedge clk);
      modelo_paso(fc, p_s, p_a);
      m_flag = fl;
      @(negedge clk);
      pulse_siguiente = 1'b0;
      pulse_actividad = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  fc;
      logic        fl, ps, pa;
      logic [11:0] cs;
      logic        modo, lect;
      logic [1:0]  grp, cur;
   } vec_t;

   vec_t tabla[21];

   initial begin
      tabla[0]  = '{3'b011, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 2'd0, 2'd0};
      tabla[1]  = '{3'b000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 2'd0, 2'd0};
      tabla[2]  = '{3'b010, 1'b1, 1'b0, 1'b0, 12'h010, 1'b1, 1'b1, 2'd1, 2'd0};
      tabla[3]  = '{3'b010, 1'b0, 1'b1, 1'b0, 12'h020, 1'b1, 1'b0, 2'd1, 2'd1};
      tabla[4]  = '{3'b010, 1'b0, 1'b1, 1'b0, 12'h040, 1'b1, 1'b0, 2'd1, 2'd2};
      tabla[5]  = '{3'b010, 1'b0, 1'b1, 1'b0, 12'h080, 1'b1, 1'b0, 2'd1, 2'd3};
      tabla[6]  = '{3'b010, 1'b0, 1'b1, 1'b0, 12'h010, 1'b1, 1'b0, 2'd1, 2'd0};
      tabla[7]  = '{3'b000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 2'd0, 2'd0};
      tabla[8]  = '{3'b001, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b1, 2'd0, 2'd0};
      tabla[9]  = '{3'b001, 1'b1, 1'b1, 1'b0, 12'h002, 1'b1, 1'b1, 2'd0, 2'd1};
      tabla[10] = '{3'b001, 1'b1, 1'b1, 1'b0, 12'h004, 1'b1, 1'b1, 2'd0, 2'd2};
      tabla[11] = '{3'b001, 1'b1, 1'b1, 1'b0, 12'h001, 1'b1, 1'b1, 2'd0, 2'd0};
      tabla[12] = '{3'b000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 2'd0, 2'd0};
      tabla[13] = '{3'b100, 1'b1, 1'b0, 1'b0, 12'h100, 1'b1, 1'b0, 2'd2, 2'd0};
      tabla[14] = '{3'b100, 1'b1, 1'b0, 1'b1, 12'h100, 1'b1, 1'b0, 2'd2, 2'd0};
      tabla[15] = '{3'b000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 2'd0, 2'd0};
      tabla[16] = '{3'b010, 1'b0, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 2'd1, 2'd0};
      tabla[17] = '{3'b010, 1'b0, 1'b1, 1'b0, 12'h020, 1'b1, 1'b0, 2'd1, 2'd1};
      tabla[18] = '{3'b010, 1'b0, 1'b1, 1'b0, 12'h040, 1'b1, 1'b0, 2'd1, 2'd2};
      tabla[19] = '{3'b100, 1'b1, 1'b1, 1'b0, 12'h100, 1'b1, 1'b0, 2'd2, 2'd0};
      tabla[20] = '{3'b111, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 2'd0, 2'd0};

      reset = 1'b1;
      funcion_conf = 3'b000; flag_mostrar_count = 1'b0;
      pulse_siguiente = 1'b0; pulse_actividad = 1'b0;
      modelo_reset();
      repeat (2) @(negedge clk);
      chk("rst_cs",    32'(cs_campo), 32'd0);
      chk("rst_modo",  32'(modo_conf), 32'd0);
      chk("rst_lect",  32'(cs_lectura_timer), 32'd0);
      chk("rst_grupo", 32'(grupo_activo), 32'd0);
      chk("rst_campo", 32'(campo_activo), 32'd0);
      chk("rst_ev",    32'(timeout_evento), 32'd0);
      chk("rst_parp",  32'(parpadeo), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         ciclo(tabla[i].fc, tabla[i].fl, tabla[i].ps, tabla[i].pa);
         chk($sformatf("tab%0d_cs", i),   32'(cs_campo), 32'(tabla[i].cs));
         chk($sformatf("tab%0d_modo", i), 32'(modo_conf), 32'(tabla[i].modo));
         chk($sformatf("tab%0d_lect", i), 32'(cs_lectura_timer), 32'(tabla[i].lect));
         if (tabla[i].modo) begin
            chk($sformatf("tab%0d_grp", i), 32'(grupo_activo), 32'(tabla[i].grp));
            chk($sformatf("tab%0d_cur", i), 32'(campo_activo), 32'(tabla[i].cur));
         end
      end

      // Idle timeout, then hold in the wait state until the switch is released.
      ciclo(3'b000, 1'b0, 1'b0, 1'b0);
      ciclo(3'b001, 1'b0, 1'b0, 1'b0);
      chk("to_entrada", 32'(modo_conf), 32'd1);
      for (int k = 1; k < TO; k++) begin
         ciclo(3'b001, 1'b0, 1'b0, 1'b0);
         chk($sformatf("to_idle%0d_ev", k), 32'(timeout_evento), 32'd0);
         chk($sformatf("to_idle%0d_modo", k), 32'(modo_conf), 32'd1);
      end
      ciclo(3'b001, 1'b0, 1'b0, 1'b0);
      chk("to_expira_ev",   32'(timeout_evento), 32'd1);
      chk("to_expira_modo", 32'(modo_conf), 32'd0);
      chk("to_expira_cs",   32'(cs_campo), 32'd0);
      for (int k = 0; k < 3; k++) begin
         ciclo(3'b001, 1'b0, 1'b0, 1'b0);
         chk("espera_ev",   32'(timeout_evento), 32'd0);
         chk("espera_modo", 32'(modo_conf), 32'd0);
         chk("espera_cs",   32'(cs_campo), 32'd0);
      end
      ciclo(3'b000, 1'b0, 1'b0, 1'b0);
      chk("liberar_modo", 32'(modo_conf), 32'd0);
      ciclo(3'b001, 1'b0, 1'b0, 1'b0);
      chk("reentrada_modo", 32'(modo_conf), 32'd1);
      chk("reentrada_cs",   32'(cs_campo), 32'h001);

      // Activity pulse on the would-be expiry cycle keeps CONFIG alive.
      for (int k = 1; k < TO; k++) ciclo(3'b001, 1'b0, 1'b0, 1'b0);
      ciclo(3'b001, 1'b0, 1'b0, 1'b1);
      chk("act_expira_ev",   32'(timeout_evento), 32'd0);
      chk("act_expira_modo", 32'(modo_conf), 32'd1);
      for (int k = 0; k < 5; k++) begin
         ciclo(3'b001, 1'b0, 1'b0, 1'b0);
         chk("act_despues_ev", 32'(timeout_evento), 32'd0);
      end
      ciclo(3'b000, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of CONFIG.
      ciclo(3'b010, 1'b1, 1'b0, 1'b0);
      ciclo(3'b010, 1'b1, 1'b1, 1'b0);
      ciclo(3'b010, 1'b1, 1'b1, 1'b0);
      chk("pre_rst_campo", 32'(campo_activo), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("arst_cs",    32'(cs_campo), 32'd0);
      chk("arst_modo",  32'(modo_conf), 32'd0);
      chk("arst_lect",  32'(cs_lectura_timer), 32'd0);
      chk("arst_grupo", 32'(grupo_activo), 32'd0);
      chk("arst_campo", 32'(campo_activo), 32'd0);
      chk("arst_ev",    32'(timeout_evento), 32'd0);
      chk("arst_parp",  32'(parpadeo), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      modelo_reset();
      ciclo(3'b010, 1'b0, 1'b0, 1'b0);
      chk("post_rst_modo",  32'(modo_conf), 32'd1);
      chk("post_rst_campo", 32'(campo_activo), 32'd0);
      chk("post_rst_cs",    32'(cs_campo), 32'h010);

      // Blink waveform over two full periods after entry.
      ciclo(3'b000, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2 * 2 * PB; k++) begin
         ciclo(3'b001, 1'b0, 1'b0, 1'b0);
`ifdef CS_PARPADEO_EN
         chk($sformatf("parp%0d", k), 32'(parpadeo), 32'(((k / PB) % 2) == 0));
`else
         chk($sformatf("parp%0d", k), 32'(parpadeo), 32'd0);
`endif
      end
      ciclo(3'b000, 1'b0, 1'b0, 1'b0);

      // Randomized traffic with quiet stretches so timeouts also occur.
      begin
         logic [2:0] fc = 3'b000;
         logic       fl = 1'b0;
         for (int i = 0; i < 800; i++) begin
            bit quieto = (i % 120) >= 90;
            logic ps_r, pa_r;
            if (!quieto && $urandom_range(0, 7) == 0) begin
               case ($urandom_range(0, 9))
                  1, 2:    fc = 3'b001;
                  3, 4:    fc = 3'b010;
                  5, 6:    fc = 3'b100;
                  7:       fc = 3'b011;
                  8:       fc = 3'b111;
                  default: fc = 3'b000;
               endcase
            end
            if ($urandom_range(0, 9) == 0) fl = ~fl;
            ps_r = !quieto && ($urandom_range(0, 5) == 0);
            pa_r = !quieto && ($urandom_range(0, 9) == 0);
            ciclo(fc, fl, ps_r, pa_r);
            chk_modelo();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/secuenciador_cs_campos.md
Name: secuenciador_cs_campos

Overview:
Clocked, parametrised successor to the combinational register chip-select decoder. It latches a configuration group (hora, fecha, timer) from funcion_conf and walks a field cursor through that group's fields. It drives exactly one field chip-select at a time and returns to rest automatically after an inactivity timeout. It sits between the button/debounce front end and the RTC register bank.

Parameters:
N_GRUPOS, 3, number of field groups; funcion_conf is one-hot with this width.
CAMPOS_MAX, 4, cs slots reserved per group.
CAMPOS_VEC, 9'h0E3, packed 3-bit field count per group, LSB first: hora=3, fecha=4, timer=3. Each count must be between 1 and CAMPOS_MAX.
TIMEOUT_CICLOS, 32'd100_000_000, inactivity cycles before auto-exit.
PARPADEO_CICLOS, 32'd25_000_000, half-period of the blink output (optional feature only).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
funcion_conf  in  N_GRUPOS  one-hot group request; 0 means no configuration.
flag_mostrar_count  in  1  the timer count is being displayed.
pulse_siguiente  in  1  one-cycle pulse; advance the field cursor.
pulse_actividad  in  1  one-cycle pulse (up/down edits); restarts the timeout only.
cs_campo  out  N_GRUPOS*CAMPOS_MAX  one-hot field chip-select.
cs_lectura_timer  out  1  read-select for all timer fields.
modo_conf  out  1  high while in state CONFIG.
grupo_activo  out  $clog2(N_GRUPOS)  latched group index.
campo_activo  out  $clog2(CAMPOS_MAX)  cursor index.
timeout_evento  out  1  one-cycle pulse on auto-exit.
parpadeo  out  1  field blink; see Optional Feature.

Behaviour:
- Reset: every output is 0. The FSM goes to REPOSO and the timeout counter clears. Reset takes effect immediately, including mid-CONFIG.
- All outputs are registered. A response appears on the cycle after the input is sampled (1-cycle latency).
- The FSM has three states: REPOSO, CONFIG and ESPERA_LIBERAR.
- REPOSO:
  - Valid one-hot funcion_conf -> CONFIG, with grupo_activo = index of the set bit and campo_activo = 0.
  - Zero or multi-hot funcion_conf -> stay in REPOSO.
- CONFIG:
  - cs_campo[grupo_activo*CAMPOS_MAX + campo_activo] = 1; all other bits are 0.
  - pulse_siguiente -> campo_activo+1. The cursor wraps to 0 after CAMPOS_VEC[grupo]-1.
  - funcion_conf switches to a different valid group -> re-latch the group, campo_activo = 0. This wins over a pulse_siguiente in the same cycle.
  - funcion_conf = 0 or multi-hot -> REPOSO, with cs_campo = 0.
  - The timeout counter increments each cycle. Any pulse_siguiente, pulse_actividad or group change clears it.
  - When the counter reaches TIMEOUT_CICLOS-1 with no pulse that cycle: go to ESPERA_LIBERAR, clear cs_campo and pulse timeout_evento for 1 cycle. A pulse arriving on the expiry cycle wins and clears the counter.
- ESPERA_LIBERAR: cs_campo = 0. Stay here until funcion_conf == 0, then go to REPOSO. This prevents immediate re-entry while the switch is still held.
- cs_lectura_timer = flag_mostrar_count AND NOT (state==CONFIG AND grupo_activo==timer group, i.e. N_GRUPOS-1). Editing takes priority over display reads.
- modo_conf = 1 only in CONFIG.
- Counter width is $clog2(TIMEOUT_CICLOS). The counter saturates and never wraps.

Optional Feature:
- Macro: CS_PARPADEO_EN.
- Defined:
  - parpadeo toggles every PARPADEO_CICLOS cycles while in CONFIG.
  - It restarts at 1 on entry to CONFIG and on every cursor or group change.
  - It is 0 outside CONFIG.
- Undefined: parpadeo is tied to 0 and the blink counter is not synthesised.

Decomposition:
- Package cs_campos_pkg holds:
  - FSM state typedef/localparams: REPOSO=2'd0, CONFIG=2'd1, ESPERA_LIBERAR=2'd2.
  - Group index constants: G_HORA=0, G_FECHA=1, G_TIMER=2.
  - A function that extracts the field count from CAMPOS_VEC.
- One sub-module, contador_timeout: a parametrised saturating counter with clear input and expiry flag. It is instantiated for the timeout, and for blink when CS_PARPADEO_EN is defined.

Test Plan:
- All tests use TIMEOUT_CICLOS=16 and PARPADEO_CICLOS=4.
- Reset mid-CONFIG: assert reset asynchronously with funcion_conf=3'b010 and the cursor at 2 -> all outputs 0 immediately. After release, CONFIG is re-entered with campo_activo=0.
- Wrap: funcion_conf=3'b010, then 4 pulse_siguiente -> cs_campo walks bits 4,5,6,7 and returns to bit 4. With 3'b001, 3 pulses -> bits 0,1,2,0.
- Group switch with simultaneous pulse: in fecha with the cursor at 2, set funcion_conf=3'b100 and pulse_siguiente in the same cycle -> next cycle cs_campo bit 8, grupo_activo=2.
- Timeout: hold 3'b001 idle for 16 cycles -> timeout_evento high for exactly 1 cycle and cs_campo=0. Output stays in ESPERA_LIBERAR until funcion_conf=0. A pulse_actividad on cycle 15 instead gives no timeout.
- Display override: flag_mostrar_count=1 in REPOSO -> cs_lectura_timer=1. Entering CONFIG on 3'b100 -> cs_lectura_timer=0. Entering on 3'b001 -> cs_lectura_timer=1.
- Invalid input: funcion_conf=3'b011 from REPOSO -> stays in REPOSO with all cs 0. When CS_PARPADEO_EN is defined, parpadeo has period 8 cycles in CONFIG.
